alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU, single-cycle logic/arith ops plus optional shift-add MUL
// Define ALU_SEQ_MUL_EN to build the 32-cycle multiplier; otherwise code 0011 is illegal.
module alu_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  ALUCtrl_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        illegal_o
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    logic        accept;
    logic        is_mul;
    logic        op_illegal;
    logic        mul_finish;
    logic [31:0] op_result;
    logic [31:0] mul_result;

    assign accept = start_i && !busy_o;

    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        is_mul     = 1'b0;
        case (ALUCtrl_i)
            OP_AND:  op_result = src1_i & src2_i;
            OP_OR:   op_result = src1_i | src2_i;
            OP_ADD:  op_result = src1_i + src2_i;
            OP_SUB:  op_result = src1_i - src2_i;
            OP_SLT:  op_result = ($signed(src1_i) < $signed(src2_i)) ? 32'h1 : 32'h0;
            OP_NOR:  op_result = ~(src1_i | src2_i);
            OP_NAND: op_result = ~(src1_i & src2_i);
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  is_mul = 1'b1;
`endif
            default: op_illegal = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  count;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;

    // One shift-add step; on the final iteration this is also the product.
    assign mul_result = acc + (mplier[0] ? mcand : 32'h0);
    assign busy_o     = (state == S_MUL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mul_finish = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (count == 6'd31) begin
                    mul_finish = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (state == S_IDLE) begin
            if (accept && is_mul) begin
                count  <= '0;
                acc    <= '0;
                mcand  <= src1_i;
                mplier <= src2_i;
            end
        end else begin
            count  <= count + 6'd1;
            acc    <= mul_result;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`else
    assign busy_o     = 1'b0;
    assign mul_finish = 1'b0;
    assign mul_result = '0;
`endif

    // Result flags change only on a completion; done_o is high for the cycle after it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o  <= '0;
            zero_o    <= 1'b1;
            illegal_o <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (accept && !is_mul) begin
                result_o  <= op_result;
                zero_o    <= (op_result == 32'h0);
                illegal_o <= op_illegal;
                done_o    <= 1'b1;
            end else if (mul_finish) begin
                result_o  <= mul_result;
                zero_o    <= (mul_result == 32'h0);
                illegal_o <= 1'b0;
                done_o    <= 1'b1;
            end
        end
    end

endmodule
